// File: rtl/jtag_master_if.sv
// Command/response port of the JTAG initiator.
// Valid/ready: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
// rsp_valid is a single-cycle pulse with no back-pressure.
interface jtag_master_if #(
    parameter int MAX_BITS = 32
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [5:0]          cmd_len;
    logic [MAX_BITS-1:0] cmd_data;
    logic                rsp_valid;
    logic [MAX_BITS-1:0] rsp_data;
    logic                busy;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/jtag_master.sv
// Host-side JTAG initiator: TAP reset, IR shift or DR shift of 1..MAX_BITS bits,
// returning the TDO bits captured during the shift phase.
module jtag_master #(
    parameter int CLK_DIV  = 4,
    parameter int MAX_BITS = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    jtag_master_if.slave  bus,
    output logic          tck,
    output logic          tms,
    output logic          tdi,
    input  logic          tdo,
    output logic [2:0]    dbg_state
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        SHIFT = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [5:0]    MAX_LEN  = 6'(MAX_BITS);

    state_t              state;
    logic [DW-1:0]       div_cnt;
    logic [5:0]          bit_cnt;
    logic [5:0]          nbits;
    logic [1:0]          op;
    logic [MAX_BITS-1:0] data;
    logic [MAX_BITS-1:0] cap;
    logic [MAX_BITS-1:0] rsp_data_r;
    logic                ready_r;
    logic                rsp_valid_r;
    logic [5:0]          len_eff;
    logic [1:0]          op_eff;
    logic                half_end;

    // TMS value of preamble TCK idx; op 01 = IR, 10 = DR, else TAP reset.
    function automatic logic pre_tms(input logic [1:0] o, input logic [5:0] idx);
        case (o)
            2'b01:   pre_tms = (idx < 6'd2);
            2'b10:   pre_tms = (idx == 6'd0);
            default: pre_tms = (idx < 6'd5);
        endcase
    endfunction

    function automatic logic [5:0] pre_last(input logic [1:0] o);
        case (o)
            2'b01:   pre_last = 6'd3;
            2'b10:   pre_last = 6'd2;
            default: pre_last = 6'd5;
        endcase
    endfunction

    always_comb begin
        len_eff = bus.cmd_len;
        if (bus.cmd_len == 6'd0)
            len_eff = 6'd1;
        else if (bus.cmd_len > MAX_LEN)
            len_eff = MAX_LEN;
        op_eff = (bus.cmd_op == 2'b11) ? 2'b00 : bus.cmd_op;
    end

    assign half_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            nbits       <= 6'd1;
            op          <= 2'b00;
            data        <= '0;
            cap         <= '0;
            tck         <= 1'b0;
            tms         <= 1'b1;
            tdi         <= 1'b0;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (bus.cmd_valid) begin
                        state   <= PRE;
                        op      <= op_eff;
                        nbits   <= len_eff;
                        data    <= bus.cmd_data;
                        cap     <= '0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        tck     <= 1'b0;
                        tms     <= 1'b1;
                        tdi     <= 1'b0;
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    if (!half_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!tck) begin
                            tck <= 1'b1;
                            if (state == SHIFT)
                                cap <= cap | (MAX_BITS'(tdo) << bit_cnt);
                        end else begin
                            // Falling TCK: the only point where TMS/TDI advance.
                            tck <= 1'b0;
                            case (state)
                                PRE: begin
                                    if (bit_cnt == pre_last(op)) begin
                                        if (op == 2'b00) begin
                                            state       <= DONE;
                                            ready_r     <= 1'b1;
                                            rsp_valid_r <= 1'b1;
                                            rsp_data_r  <= cap;
                                            tms         <= 1'b0;
                                            tdi         <= 1'b0;
                                        end else begin
                                            state   <= SHIFT;
                                            bit_cnt <= '0;
                                            tms     <= (nbits == 6'd1);
                                            tdi     <= data[0];
                                        end
                                    end else begin
                                        bit_cnt <= bit_cnt + 6'd1;
                                        tms     <= pre_tms(op, bit_cnt + 6'd1);
                                    end
                                end
                                SHIFT: begin
                                    if (bit_cnt == nbits - 6'd1) begin
                                        state   <= POST;
                                        bit_cnt <= '0;
                                        tms     <= 1'b1;
                                        tdi     <= 1'b0;
                                    end else begin
                                        bit_cnt <= bit_cnt + 6'd1;
                                        tms     <= (bit_cnt + 6'd2 == nbits);
                                        data    <= data >> 1;
                                        tdi     <= data[1];
                                    end
                                end
                                POST: begin
                                    if (bit_cnt != 6'd0) begin
                                        state       <= DONE;
                                        ready_r     <= 1'b1;
                                        rsp_valid_r <= 1'b1;
                                        rsp_data_r  <= cap;
                                        tms         <= 1'b0;
                                        tdi         <= 1'b0;
                                    end else begin
                                        bit_cnt <= 6'd1;
                                        tms     <= 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_r;
    assign bus.busy      = ~ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign dbg_state     = state;
endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: a behavioural TAP target (6-bit IR, 32-bit loopback DR) on the pins
// and an arithmetic reference of the expected TMS/TDI streams, latency and captured data.
module tb_jtag_master;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tck, tms, tdi, tdo;
    logic [2:0] dbg_state;

    jtag_master_if #(.MAX_BITS(32)) bus();

    jtag_master #(.CLK_DIV(DIV), .MAX_BITS(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- TAP target model ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_t;

    localparam logic [5:0] IR_CAP = 6'b110101;

    tap_t        tap    = TLR;
    logic [5:0]  ir     = 6'd0;
    logic [5:0]  ir_upd = 6'd0;
    logic [31:0] dr     = 32'h1234_5678;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:     return m ? TLR    : RTI;
            RTI:     return m ? SEL_DR : RTI;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SH_DR;
            SH_DR:   return m ? EX1_DR : SH_DR;
            EX1_DR:  return m ? UPD_DR : PAU_DR;
            PAU_DR:  return m ? EX2_DR : PAU_DR;
            EX2_DR:  return m ? UPD_DR : SH_DR;
            UPD_DR:  return m ? SEL_DR : RTI;
            SEL_IR:  return m ? TLR    : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SH_IR;
            SH_IR:   return m ? EX1_IR : SH_IR;
            EX1_IR:  return m ? UPD_IR : PAU_IR;
            PAU_IR:  return m ? EX2_IR : PAU_IR;
            EX2_IR:  return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        case (tap)
            CAP_IR:  ir     <= IR_CAP;
            SH_IR:   ir     <= {tdi, ir[5:1]};
            UPD_IR:  ir_upd <= ir;
            SH_DR:   dr     <= {tdi, dr[31:1]};
            default: ;
        endcase
        tap <= tap_next(tap, tms);
    end

    assign tdo = (tap == SH_DR) ? dr[0] : (tap == SH_IR) ? ir[0] : 1'b0;

    // Pin history: TMS/TDI seen at every rising TCK.
    logic tms_hist[$];
    logic tdi_hist[$];
    always @(posedge tck) begin
        tms_hist.push_back(tms);
        tdi_hist.push_back(tdi);
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference expectations ----------------
    int          exp_k;
    logic [63:0] exp_tms;
    logic [63:0] exp_tdi;
    logic [5:0]  exp_ir = 6'd0;
    logic [31:0] exp_dr = 32'h1234_5678;
    logic [1:0]  last_op;
    int          base_rise;
    int unsigned acc_cyc;

    // Computes the expected pin streams and result, then presents the command for one edge.
    // Call with the bench positioned between edges and the DUT ready.
    task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data);
        int          n;
        int          npre;
        logic [63:0] mask;
        logic [63:0] cat;
        logic [63:0] sh;
        n = (len == 6'd0) ? 1 : (len > 6'd32) ? 32 : int'(len);
        mask = (64'd1 << n) - 64'd1;
        exp_tms = 64'd0;
        exp_tdi = 64'd0;
        last_op = (op == 2'b11) ? 2'b00 : op;
        if (last_op == 2'b00) begin
            exp_tms = 64'h1F;
            exp_k   = 6;
            exp_q.push_back(32'd0);
        end else begin
            npre = (last_op == 2'b01) ? 4 : 3;
            for (int i = 0; i < npre; i++) exp_tms[i] = (i < npre - 2);
            for (int i = 0; i < n; i++) begin
                exp_tms[npre + i] = (i == n - 1);
                exp_tdi[npre + i] = data[i];
            end
            exp_tms[npre + n]     = 1'b1;
            exp_tms[npre + n + 1] = 1'b0;
            exp_k = npre + n + 2;
            if (last_op == 2'b10) begin
                cat = {data, exp_dr};
                sh  = cat >> n;
                exp_dr = sh[31:0];
            end else begin
                cat = ({32'd0, data} << 6) | {58'd0, IR_CAP};
                sh  = cat >> n;
                exp_ir = sh[5:0];
            end
            cat = cat & mask;
            exp_q.push_back(cat[31:0]);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        @(posedge clk);
        base_rise = tms_hist.size();
        #1;
        bus.cmd_valid = 1'b0;
        acc_cyc = cyc;
        @(negedge clk);
        check("busy_after_accept", 64'(bus.busy), 64'd1);
    endtask

    // Waits (bounded) for the response, poking cmd_valid once mid-command, then checks everything.
    task automatic finish_cmd(input bit chk_rsp);
        int          waited;
        int          pulse_at;
        int          limit;
        logic [31:0] e;
        logic [63:0] got_tms;
        logic [63:0] got_tdi;
        limit    = 2 * DIV * exp_k + 20;
        pulse_at = $urandom_range(1, 2 * DIV * exp_k - 4);
        waited   = 0;
        while (!bus.rsp_valid && waited < limit) begin
            if (waited == pulse_at) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 2'($urandom_range(0, 3));
                bus.cmd_len   = 6'($urandom_range(0, 63));
                bus.cmd_data  = $urandom;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            @(negedge clk);
            waited++;
        end
        bus.cmd_valid = 1'b0;
        e = exp_q.pop_front();
        if (!bus.rsp_valid) begin
            check("rsp_timeout", 64'd0, 64'd1);
        end else begin
            check("latency", 64'(cyc - acc_cyc), 64'(2 * DIV * exp_k));
            check("tck_rises", 64'(tms_hist.size() - base_rise), 64'(exp_k));
            got_tms = 64'd0;
            got_tdi = 64'd0;
            for (int k = 0; k < exp_k && base_rise + k < tms_hist.size(); k++) begin
                got_tms[k] = tms_hist[base_rise + k];
                got_tdi[k] = tdi_hist[base_rise + k];
            end
            check("tms_seq", got_tms, exp_tms);
            check("tdi_seq", got_tdi, exp_tdi);
            if (chk_rsp) check("rsp_data", 64'(bus.rsp_data), 64'(e));
            check("tck_at_done", 64'(tck), 64'd0);
            check("tms_at_done", 64'(tms), 64'd0);
            check("ready_at_done", 64'(bus.cmd_ready), 64'd1);
            check("tap_in_rti", 64'(tap == RTI), 64'd1);
            if (last_op == 2'b01) check("ir_update", 64'(ir_upd), 64'(exp_ir));
            if (last_op == 2'b10) check("dr_model", 64'(dr), 64'(exp_dr));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tck"}, 64'(tck), 64'd0);
        check({tag, "_tms"}, 64'(tms), 64'd1);
        check({tag, "_tdi"}, 64'(tdi), 64'd0);
        check({tag, "_ready"}, 64'(bus.cmd_ready), 64'd1);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = 6'd0;
        bus.cmd_data  = 32'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed cases, back-to-back.
        issue(2'b00, 6'd0, 32'd0);
        finish_cmd(1'b1);
        issue(2'b01, 6'd6, 32'h23);
        finish_cmd(1'b1);
        issue(2'b10, 6'd32, 32'hA5C3_0F96);
        finish_cmd(1'b1);
        issue(2'b10, 6'd0, $urandom);
        finish_cmd(1'b1);
        issue(2'b10, 6'd40, $urandom);
        finish_cmd(1'b1);
        issue(2'b11, 6'd17, $urandom);
        finish_cmd(1'b1);

        // Randomized commands.
        for (int i = 0; i < 16; i++) begin
            issue(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), $urandom);
            finish_cmd(1'b1);
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        // Reset during bit 10 of a 32-bit DR shift (rise index 3 + 10).
        issue(2'b10, 6'd32, $urandom);
        guard = 0;
        while (tms_hist.size() < base_rise + 13 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check("midreset_wait_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        void'(exp_q.pop_back());
        rst_n = 1'b1;

        issue(2'b00, 6'd0, 32'd0);
        finish_cmd(1'b1);
        issue(2'b10, 6'd32, 32'h0BAD_F00D);   // DR contents unknown: flush with a known word
        finish_cmd(1'b0);
        issue(2'b10, 6'd32, $urandom);
        finish_cmd(1'b1);
        issue(2'b01, 6'd6, $urandom);
        finish_cmd(1'b1);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
